// File: rtl/apb_master.sv
// APB master: turns single req/rsp commands into APB SETUP/ACCESS transfers on one of four slaves.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [3:0]  PSEL,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;
  logic   timeout;

  function automatic logic [3:0] slave_sel(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Only slave-select and word-offset bits of the address reach the bus.
  logic unused_inputs;
  assign unused_inputs = ^{req_addr[15:14], req_addr[11:4], TO_LAST};

  assign req_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       rsp_err_q;

  // Counter is zeroed during SETUP so it starts at 0 in the first ACCESS cycle.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign timeout = (state == ACCESS) && !PREADY && (to_cnt == TO_LAST);

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      rsp_err_q <= 1'b0;
    end else if (state == ACCESS && (PREADY || timeout)) begin
      rsp_err_q <= !PREADY;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and response registers; address/data hold their last values while idle.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PENABLE   <= 1'b0;
      PSEL      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR  <= req_addr[3:0];
            PWDATA <= req_wdata;
            PWRITE <= req_write;
            PSEL   <= slave_sel(req_addr[13:12]);
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY || timeout) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            if (PREADY && !PWRITE) rsp_rdata <= PRDATA;
          end
        end
        default: begin
          PSEL    <= '0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: table-driven single transfers plus back-to-back, reset-abort and timeout sequences.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  int n_checks = 0;
  int n_err    = 0;

  apb_master #(.TIMEOUT_CYC(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic [3:0]  psel;
    logic [3:0]  paddr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_vec(input vec_t v);
    chk("idle req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    PREADY = 1'b1;
    @(negedge PCLK);
    req_valid = 1'b0; req_wdata = 32'hCAFE_0000; req_addr = 16'hFFFF;
    chk("setup PSEL", PSEL, v.psel);
    chk("setup PENABLE", PENABLE, 0);
    chk("setup PADDR", PADDR, v.paddr);
    chk("setup PWRITE", PWRITE, v.wr);
    if (v.wr) chk("setup PWDATA", PWDATA, v.wdata);
    chk("setup req_ready", req_ready, 0);
    chk("setup rsp_valid", rsp_valid, 0);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge PCLK);
      chk("access PENABLE", PENABLE, 1);
      chk("access PSEL", PSEL, v.psel);
      chk("access PADDR", PADDR, v.paddr);
      chk("access PWRITE", PWRITE, v.wr);
      if (v.wr) chk("access PWDATA", PWDATA, v.wdata);
      chk("access req_ready", req_ready, 0);
      chk("access rsp_valid", rsp_valid, 0);
      PREADY = (k == v.waits);
      PRDATA = (k == v.waits) ? v.prdata : ~v.prdata;
    end
    @(negedge PCLK);
    PREADY = 1'b0; PRDATA = 32'h0;
    chk("rsp rsp_valid", rsp_valid, 1);
    chk("rsp rsp_err", rsp_err, 0);
    chk("rsp rsp_rdata", rsp_rdata, v.rdata);
    chk("rsp PSEL", PSEL, 0);
    chk("rsp PENABLE", PENABLE, 0);
    chk("rsp req_ready", req_ready, 1);
    chk("rsp PADDR hold", PADDR, v.paddr);
    @(negedge PCLK);
    chk("post rsp_valid", rsp_valid, 0);
    chk("post rsp_rdata hold", rsp_rdata, v.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, nset, nrsp, n_acc;
    logic acc, seen;

    vecs[0] = '{1'b1, 16'h2008, 32'h0000_00A5, 0, 32'h0,         4'b0100, 4'h8, 32'h0};
    vecs[1] = '{1'b0, 16'h000C, 32'h0,         2, 32'h0000_003C, 4'b0001, 4'hC, 32'h0000_003C};
    vecs[2] = '{1'b0, 16'h3005, 32'h0,         0, 32'hDEAD_BEEF, 4'b1000, 4'h5, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 16'h100F, 32'h1234_5678, 1, 32'h0,         4'b0010, 4'hF, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 16'hF3F0, 32'h0,         3, 32'h0BAD_F00D, 4'b1000, 4'h0, 32'h0BAD_F00D};
    vecs[5] = '{1'b1, 16'h2FF7, 32'hFFFF_FFFF, 0, 32'h0,         4'b0100, 4'h7, 32'h0BAD_F00D};

    PRESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("reset PSEL", PSEL, 0);
    chk("reset PENABLE", PENABLE, 0);
    chk("reset PWRITE", PWRITE, 0);
    chk("reset PADDR", PADDR, 0);
    chk("reset PWDATA", PWDATA, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err", rsp_err, 0);
    chk("reset req_ready", req_ready, 1);
    PRESET = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back writes with req_valid held high and zero wait states.
    req_write = 1'b1; req_addr = 16'h1000; req_wdata = 32'd0; req_valid = 1'b1; PREADY = 1'b1;
    idx = 0; nset = 0; nrsp = 0;
    acc = req_ready;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge PCLK);
      if (PSEL != 4'b0000 && !PENABLE) begin
        chk("b2b setup PADDR", PADDR, 32'(nset));
        chk("b2b setup PWDATA", PWDATA, 32'(nset));
        chk("b2b setup PSEL", PSEL, 4'b0010);
        nset++;
      end
      if (PSEL != 4'b0000) chk("b2b busy req_ready", req_ready, 0);
      if (rsp_valid) begin
        nrsp++;
        chk("b2b rsp cycle", cyc, 3 * nrsp);
      end
      if (acc) begin
        idx++;
        if (idx < 4) begin
          req_addr = 16'h1000 + 16'(idx);
          req_wdata = 32'(idx);
        end else begin
          req_valid = 1'b0;
        end
      end
      acc = req_valid && req_ready;
    end
    chk("b2b rsp count", nrsp, 4);
    chk("b2b setup count", nset, 4);
    PREADY = 1'b0;

    // Reset asserted during ACCESS of a read.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1004;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("abort in ACCESS", PENABLE, 1);
    PRESET = 1'b0;
    #1;
    chk("abort PSEL", PSEL, 0);
    chk("abort PENABLE", PENABLE, 0);
    chk("abort PADDR", PADDR, 0);
    chk("abort rsp_rdata", rsp_rdata, 0);
    @(negedge PCLK);
    PRESET = 1'b1; PREADY = 1'b1; PRDATA = 32'h77;
    chk("abort release req_ready", req_ready, 1);
    repeat (3) begin
      @(negedge PCLK);
      chk("abort no rsp_valid", rsp_valid, 0);
      chk("abort idle PSEL", PSEL, 0);
    end
    PREADY = 1'b0;
    run_vec(vecs[2]);

`ifdef APB_MASTER_TIMEOUT_EN
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h2004; PREADY = 1'b0; PRDATA = 32'h5555_5555;
    @(negedge PCLK);
    req_valid = 1'b0;
    n_acc = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        seen = 1'b1;
        chk("timeout rsp_err", rsp_err, 1);
        chk("timeout rsp_rdata hold", rsp_rdata, 32'hDEAD_BEEF);
        chk("timeout PSEL", PSEL, 0);
        chk("timeout PENABLE", PENABLE, 0);
        chk("timeout req_ready", req_ready, 1);
      end else if (PENABLE) begin
        n_acc++;
      end
    end
    chk("timeout rsp seen", seen, 1);
    chk("timeout access cycles", n_acc, 4);
    @(negedge PCLK);
    chk("timeout pulse width", rsp_valid, 0);
`else
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h2004; PREADY = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge PCLK);
      if (rsp_valid) seen = 1'b1;
    end
    chk("stall no rsp_valid", seen, 0);
    chk("stall PENABLE held", PENABLE, 1);
    chk("stall PSEL held", PSEL, 4'b0100);
    chk("stall rsp_err tied", rsp_err, 0);
    PRESET = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("stall recovered req_ready", req_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
